wb_spraid_ctrl: RTL and testbench
=================================

# wb_spraid_ctrl

Parametrised Wishbone front-end for the SPI RAID subsystem. It sits between the Wishbone bus and NUM_DISKS per-disk SPI engines. It decodes a linear memory window plus a small register bank, and maps each memory access onto one disk (RAID0 striping) or all enabled disks (RAID1 mirroring). It adds per-disk request/acknowledge tracking, error reporting on wb_err_o, degraded-mode tracking, and an optional watchdog.

## Interface
- NUM_DISKS, 4: number of disk channels; power of two, 2..8.
- ADDR_BASE, 32'h3000_0000: base of memory window.
- MEM_AW, 11: window size is 2^MEM_AW addresses. Registers follow the window at ADDR_BASE+2^MEM_AW+{0,1,2,3}.
- TIMEOUT_CYCLES, 1023: watchdog limit in the WAIT state.
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  reset, synchronous, active-low.
- wb_adr_i  in  32  address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; reset 0.
- wb_we_i, wb_stb_i, wb_cyc_i  in  1  standard Wishbone.
- wb_ack_o  out  1  one-cycle acknowledge; reset 0.
- wb_err_o  out  1  one-cycle error response; reset 0.
- wb_stall_o  out  1  high whenever the FSM is not IDLE; reset 0.
- wb_rty_o  out  1  tied 0.
- dsk_req_o  out  NUM_DISKS  per-disk request, level; reset 0.
- dsk_we_o  out  1  write flag, shared; reset 0.
- dsk_adr_o  out  MEM_AW  per-disk offset, shared; reset 0.
- dsk_dat_o  out  32  write data, shared; reset 0.
- dsk_dat_i  in  32*NUM_DISKS  read data; disk d occupies [32d+31:32d].
- dsk_ack_i  in  NUM_DISKS  one-cycle completion pulse.
- dsk_err_i  in  NUM_DISKS  error qualifier, valid with dsk_ack_i.

## Operation
- Accept condition: wb_cyc_i & wb_stb_i & ~wb_stall_o. Address is offset = wb_adr_i − ADDR_BASE.
- Registers, all reset values listed:
  - RAID_TYPE (+0): R/W [7:0]; reset 1. 1 = RAID0, 2 = RAID1, other = invalid.
  - STATUS (+1):
    - [0] busy
    - [1] last_err
    - [2] timeout, sticky
    - [3] degraded (fail mask & enable mask nonzero)
    - [8+:NUM_DISKS] fail mask, sticky
    - Write-1-to-clear on [2] and the fail mask.
  - DISK_EN (+2): R/W [NUM_DISKS-1:0]; reset all ones.
  - ERR_CNT (+3): 16-bit saturating count of error responses; any write clears it.
- Register accesses complete in RESP without touching disks. Any address outside the window and registers gets a wb_err_o response.
- RAID0 addressing:
  - Target disk = offset[log2(NUM_DISKS)-1:0].
  - dsk_adr_o = offset >> log2(NUM_DISKS), zero-extended to MEM_AW.
  - If the target is disabled or failed, respond with err and do not assert any request.
- RAID1 addressing:
  - dsk_adr_o = offset.
  - Write target set = enabled & ~failed.
  - Read target = lowest-index disk in that set.
  - Empty set gives an err response.
- Invalid RAID_TYPE on a memory access gives an err response.
- FSM:
  - IDLE → ISSUE on accept; latch address, data, we and target set.
  - ISSUE (1 cycle): raise dsk_req_o for the target set → WAIT.
  - WAIT: per disk, clear dsk_req_o[d] on the edge after dsk_ack_i[d]; pending mask &= ~ack. When pending reaches 0 → RESP.
  - RESP (1 cycle): drive ack or err → IDLE.
- Error resolution:
  - dsk_err_i with an ack sets that disk's fail bit.
  - RAID1 write: ack if at least one target succeeded, otherwise err.
  - RAID0 and all reads: err if the addressed disk errored.
  - Read data comes from the read target's dsk_dat_i and is registered into wb_dat_o in RESP.
- Cycle abort: if wb_cyc_i drops before RESP, disk operations still complete, but RESP drives neither ack nor err. Status updates still occur.
- Acks on non-targeted disks, or acks outside WAIT, are ignored.

## Timing
- Register access: accept at cycle 0, ack/err at cycle 2.
- Disk access:
  - accept at cycle 0
  - dsk_req_o high from cycle 1
  - last dsk_ack_i at cycle k
  - wb_ack_o at cycle k+1
- wb_stall_o is high from cycle 1 until the cycle after RESP. One transaction is outstanding at a time.
- Simultaneous acks from several disks in the same cycle all clear together.
- A reset asserted mid-transaction drops all outputs to their reset values at the next edge. Any in-flight disk ack is then ignored.

## Configuration
- SPRAID_TIMEOUT_EN defined:
  - A counter runs in WAIT. When it reaches TIMEOUT_CYCLES, pending disks are marked failed and their requests drop.
  - STATUS[2] is set.
  - The response follows the error rules, with timed-out disks counted as errored.
- SPRAID_TIMEOUT_EN undefined: WAIT is unbounded, STATUS[2] reads 0, and no counter is present.

## Structure
- Package spraid_pkg holds:
  - RAID type encodings
  - register offsets (+0..+3)
  - STATUS bit positions
  - FSM state enum
- Sub-module spraid_addr_map (combinational) computes the target set, dsk_adr_o and a map-error flag from offset, RAID_TYPE, DISK_EN and the fail mask.

## Test plan
- Reset, then read RAID_TYPE and DISK_EN → 0x1 and 0xF. wb_ack_o arrives 2 cycles after accept.
- RAID0, NUM_DISKS=4, write 0xDEADBEEF to offset 0x006 → only dsk_req_o[2] is asserted, with dsk_adr_o=0x001. An ack from disk 2 at cycle 5 gives wb_ack_o at cycle 6.
- RAID1 write with disk 1 returning dsk_err_i → wb_ack_o, STATUS fail mask = 0x2, STATUS[3]=1. A subsequent RAID0 access to a disk-1 address → wb_err_o, and ERR_CNT=1.
- RAID1 read with DISK_EN=0xC → only dsk_req_o[2] is asserted, and wb_dat_o equals dsk_dat_i[95:64].
- With SPRAID_TIMEOUT_EN and TIMEOUT_CYCLES=16, a disk that never acks → wb_err_o at cycle 18 after accept, STATUS[2]=1. Writing STATUS 0xF04 then clears the sticky bits.
- wb_cyc_i dropped during WAIT → no ack or err is driven. The next transaction is accepted normally after the disk ack.

Source files
------------

// File: rtl/spraid_pkg.sv
// Shared definitions for the SPI RAID Wishbone front-end.
//   RAID_TYPE encodings, register offsets relative to the end of the memory
//   window, STATUS bit positions and the controller FSM state type.
package spraid_pkg;

    localparam logic [7:0] RAID_T0 = 8'd1;
    localparam logic [7:0] RAID_T1 = 8'd2;

    localparam logic [1:0] REG_RAID_TYPE = 2'd0;
    localparam logic [1:0] REG_STATUS    = 2'd1;
    localparam logic [1:0] REG_DISK_EN   = 2'd2;
    localparam logic [1:0] REG_ERR_CNT   = 2'd3;

    localparam int ST_BUSY     = 0;
    localparam int ST_LAST_ERR = 1;
    localparam int ST_TIMEOUT  = 2;
    localparam int ST_DEGRADED = 3;
    localparam int ST_FAIL_LSB = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/spraid_addr_map.sv
// Combinational address mapper: turns a window offset into the set of disks
// to request, the shared per-disk offset and a map-error flag.
//   offset_i    window offset (low MEM_AW bits)
//   raid_type_i RAID_TYPE register
//   disk_en_i   DISK_EN register
//   fail_i      sticky fail mask
//   we_i        access is a write
//   tgt_o       target disk set (one-hot for RAID0 and RAID1 reads)
//   adr_o       offset presented to the disks
//   map_err_o   access cannot be served (invalid type, unusable target)
module spraid_addr_map
    import spraid_pkg::*;
#(
    parameter int NUM_DISKS = 4,
    parameter int MEM_AW    = 11
) (
    input  logic [MEM_AW-1:0]    offset_i,
    input  logic [7:0]           raid_type_i,
    input  logic [NUM_DISKS-1:0] disk_en_i,
    input  logic [NUM_DISKS-1:0] fail_i,
    input  logic                 we_i,
    output logic [NUM_DISKS-1:0] tgt_o,
    output logic [MEM_AW-1:0]    adr_o,
    output logic                 map_err_o
);

    localparam int LOG2 = $clog2(NUM_DISKS);
    localparam logic [NUM_DISKS-1:0] ONE = NUM_DISKS'(1);

    logic [NUM_DISKS-1:0] avail;

    always_comb begin
        avail     = disk_en_i & ~fail_i;
        tgt_o     = '0;
        adr_o     = '0;
        map_err_o = 1'b1;
        if (raid_type_i == RAID_T0) begin
            tgt_o     = ONE << offset_i[LOG2-1:0];
            adr_o     = offset_i >> LOG2;
            map_err_o = ~|(tgt_o & avail);
        end else if (raid_type_i == RAID_T1) begin
            adr_o     = offset_i;
            // Reads go to the lowest usable disk: isolate the lowest set bit.
            tgt_o     = we_i ? avail : (avail & (~avail + ONE));
            map_err_o = ~|avail;
        end
    end

endmodule

// File: rtl/wb_spraid_ctrl.sv
// Wishbone front-end for the SPI RAID subsystem. Decodes a memory window
// (striped or mirrored onto NUM_DISKS SPI engines) and a 4-entry register
// bank (RAID_TYPE, STATUS, DISK_EN, ERR_CNT) placed just above the window.
//   wb_*_i / wb_*_o   Wishbone slave; one transaction outstanding, stall while busy
//   dsk_req_o         per-disk level request, dropped after that disk's ack
//   dsk_we_o/adr_o/dat_o  shared command to the disks
//   dsk_dat_i/ack_i/err_i per-disk read data, completion pulse, error qualifier
// Build option: SPRAID_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYCLES.
//
// state | meaning
// IDLE  | waiting for a Wishbone request
// ISSUE | requests raised / register access performed
// WAIT  | collecting disk acks until nothing is pending
// RESP  | drive ack or err for one cycle (suppressed if the cycle was aborted)
module wb_spraid_ctrl
    import spraid_pkg::*;
#(
    parameter int          NUM_DISKS      = 4,
    parameter logic [31:0] ADDR_BASE      = 32'h3000_0000,
    parameter int          MEM_AW         = 11,
    parameter int          TIMEOUT_CYCLES = 1023
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_n_i,
    input  logic [31:0]             wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    input  logic                    wb_we_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_cyc_i,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic                    wb_stall_o,
    output logic                    wb_rty_o,
    output logic [NUM_DISKS-1:0]    dsk_req_o,
    output logic                    dsk_we_o,
    output logic [MEM_AW-1:0]       dsk_adr_o,
    output logic [31:0]             dsk_dat_o,
    input  logic [32*NUM_DISKS-1:0] dsk_dat_i,
    input  logic [NUM_DISKS-1:0]    dsk_ack_i,
    input  logic [NUM_DISKS-1:0]    dsk_err_i
);

    if (NUM_DISKS < 2 || NUM_DISKS > 8 || (NUM_DISKS & (NUM_DISKS - 1)) != 0) begin : g_chk_disks
        $error("NUM_DISKS must be a power of two in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    localparam logic [31:0] WIN_SIZE = 32'(1) << MEM_AW;

    state_e state_q, state_d;

    logic [31:0]          offset, reg_off, reg_rdata, status_w, dat_q, wdat_q;
    logic                 is_mem, is_reg, accept;
    logic [NUM_DISKS-1:0] map_tgt, pending_d, tmo_mask, fail_new;
    logic [MEM_AW-1:0]    map_adr, adr_q;
    logic                 map_err;

    logic                 is_reg_q, bad_q, we_q, raid1_q, abort_q;
    logic [1:0]           reg_sel_q;
    logic [NUM_DISKS-1:0] tgt_q, req_q, err_m_q, fail_q, disk_en_q;
    logic [7:0]           raid_type_q;
    logic                 timeout_q, last_err_q;
    logic [15:0]          err_cnt_q;
    logic                 tmo_fire, ok_disk, resp_err;

    assign offset  = wb_adr_i - ADDR_BASE;
    assign is_mem  = offset < WIN_SIZE;
    assign reg_off = offset - WIN_SIZE;
    assign is_reg  = reg_off < 32'd4;
    assign accept  = wb_cyc_i & wb_stb_i & (state_q == S_IDLE);

    spraid_addr_map #(
        .NUM_DISKS (NUM_DISKS),
        .MEM_AW    (MEM_AW)
    ) u_map (
        .offset_i    (offset[MEM_AW-1:0]),
        .raid_type_i (raid_type_q),
        .disk_en_i   (disk_en_q),
        .fail_i      (fail_q),
        .we_i        (wb_we_i),
        .tgt_o       (map_tgt),
        .adr_o       (map_adr),
        .map_err_o   (map_err)
    );

`ifdef SPRAID_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q;

    // Loaded in ISSUE so the terminal count lands on the last allowed WAIT cycle.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i)
            tmo_cnt_q <= '0;
        else if (state_q == S_ISSUE)
            tmo_cnt_q <= TW'(TIMEOUT_CYCLES - 1);
        else if (state_q == S_WAIT && tmo_cnt_q != '0)
            tmo_cnt_q <= tmo_cnt_q - TW'(1);
    end

    assign tmo_fire = (state_q == S_WAIT) && (tmo_cnt_q == '0);
`else
    assign tmo_fire = 1'b0;
`endif

    assign tmo_mask  = tmo_fire ? (req_q & ~dsk_ack_i) : '0;
    assign fail_new  = req_q & ((dsk_ack_i & dsk_err_i) | tmo_mask);
    assign pending_d = req_q & ~dsk_ack_i & ~tmo_mask;

    // Mirrored writes survive as long as one copy landed; everything else
    // has a single addressed disk whose error is the response.
    assign ok_disk  = (we_q & raid1_q) ? |(tgt_q & ~err_m_q) : ~|(tgt_q & err_m_q);
    assign resp_err = ~is_reg_q & (bad_q | ~ok_disk);

    always_comb begin
        status_w = '0;
        status_w[ST_BUSY]     = |req_q;
        status_w[ST_LAST_ERR] = last_err_q;
        status_w[ST_TIMEOUT]  = timeout_q;
        status_w[ST_DEGRADED] = |(fail_q & disk_en_q);
        status_w[ST_FAIL_LSB +: NUM_DISKS] = fail_q;
        reg_rdata = '0;
        case (reg_sel_q)
            REG_RAID_TYPE: reg_rdata = {24'h0, raid_type_q};
            REG_STATUS:    reg_rdata = status_w;
            REG_DISK_EN:   reg_rdata = 32'(disk_en_q);
            default:       reg_rdata = {16'h0, err_cnt_q};
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        wb_ack_o   = 1'b0;
        wb_err_o   = 1'b0;
        wb_stall_o = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: state_d = (|req_q) ? S_WAIT : S_RESP;
            S_WAIT:  if (pending_d == '0) state_d = S_RESP;
            S_RESP: begin
                wb_ack_o = ~abort_q & ~resp_err;
                wb_err_o = ~abort_q & resp_err;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            is_reg_q    <= 1'b0;
            bad_q       <= 1'b0;
            we_q        <= 1'b0;
            raid1_q     <= 1'b0;
            abort_q     <= 1'b0;
            reg_sel_q   <= '0;
            tgt_q       <= '0;
            req_q       <= '0;
            err_m_q     <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            dat_q       <= '0;
            raid_type_q <= RAID_T0;
            disk_en_q   <= '1;
            fail_q      <= '0;
            timeout_q   <= 1'b0;
            last_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    is_reg_q  <= is_reg;
                    bad_q     <= ~is_reg & (~is_mem | map_err);
                    reg_sel_q <= reg_off[1:0];
                    we_q      <= wb_we_i;
                    wdat_q    <= wb_dat_i;
                    adr_q     <= map_adr;
                    tgt_q     <= map_tgt;
                    raid1_q   <= (raid_type_q == RAID_T1);
                    err_m_q   <= '0;
                    abort_q   <= 1'b0;
                    req_q     <= (is_mem & ~map_err) ? map_tgt : '0;
                end
                S_ISSUE: begin
                    if (!wb_cyc_i) abort_q <= 1'b1;
                    if (is_reg_q && we_q) begin
                        case (reg_sel_q)
                            REG_RAID_TYPE: raid_type_q <= wdat_q[7:0];
                            REG_STATUS: begin
                                fail_q <= fail_q & ~wdat_q[ST_FAIL_LSB +: NUM_DISKS];
                                if (wdat_q[ST_TIMEOUT]) timeout_q <= 1'b0;
                            end
                            REG_DISK_EN:   disk_en_q <= wdat_q[NUM_DISKS-1:0];
                            default:       err_cnt_q <= '0;
                        endcase
                    end else if (is_reg_q) begin
                        dat_q <= reg_rdata;
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) abort_q <= 1'b1;
                    req_q   <= pending_d;
                    err_m_q <= err_m_q | fail_new;
                    fail_q  <= fail_q | fail_new;
                    if (tmo_fire) timeout_q <= 1'b1;
                    for (int d = 0; d < NUM_DISKS; d++)
                        if (!we_q && req_q[d] && dsk_ack_i[d]) dat_q <= dsk_dat_i[32*d +: 32];
                end
                S_RESP: begin
                    last_err_q <= resp_err;
                    if (!abort_q && resp_err && err_cnt_q != 16'hFFFF)
                        err_cnt_q <= err_cnt_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_rty_o  = 1'b0;
    assign dsk_req_o = req_q;
    assign dsk_we_o  = we_q;
    assign dsk_adr_o = adr_q;
    assign dsk_dat_o = wdat_q;

endmodule

// File: tb/tb_wb_spraid_ctrl.sv
// Directed bench for wb_spraid_ctrl (4 disks, 2 KiB window, 16-cycle watchdog).
// Cycle 0 is the cycle in which the request is accepted; latencies below are
// counted in cycles from there. Inputs change and outputs are sampled on the
// falling edge.
module tb_wb_spraid_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] REGA = BASE + 32'h0000_0800;

    logic         clk = 1'b0;
    logic         wb_rst_n;
    logic [31:0]  wb_adr, wb_wdat, wb_dat_o;
    logic         wb_we, wb_stb, wb_cyc;
    logic         wb_ack_o, wb_err_o, wb_stall_o, wb_rty_o;
    logic [3:0]   dsk_req_o;
    logic         dsk_we_o;
    logic [10:0]  dsk_adr_o;
    logic [31:0]  dsk_dat_o;
    logic [127:0] dsk_dat;
    logic [3:0]   dsk_ack, dsk_err;

    int           dly [4];
    int           cnt [4];
    logic [3:0]   errc, never;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_spraid_ctrl #(
        .NUM_DISKS      (4),
        .ADDR_BASE      (BASE),
        .MEM_AW         (11),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (wb_rst_n),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_wdat),
        .wb_dat_o   (wb_dat_o),
        .wb_we_i    (wb_we),
        .wb_stb_i   (wb_stb),
        .wb_cyc_i   (wb_cyc),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_stall_o (wb_stall_o),
        .wb_rty_o   (wb_rty_o),
        .dsk_req_o  (dsk_req_o),
        .dsk_we_o   (dsk_we_o),
        .dsk_adr_o  (dsk_adr_o),
        .dsk_dat_o  (dsk_dat_o),
        .dsk_dat_i  (dsk_dat),
        .dsk_ack_i  (dsk_ack),
        .dsk_err_i  (dsk_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Disk model: disk d acks on the dly[d]-th cycle its request is seen high.
    initial begin
        dsk_ack = '0;
        dsk_err = '0;
        for (int d = 0; d < 4; d++) cnt[d] = 0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (dsk_req_o[d]) cnt[d]++;
                else              cnt[d] = 0;
                dsk_ack[d] = dsk_req_o[d] && (cnt[d] == dly[d]) && !never[d];
                dsk_err[d] = dsk_ack[d] && errc[d];
            end
        end
    end

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           output logic ack, output logic err, output logic [31:0] rdat,
                           output int lat, output logic [3:0] req1, output logic [10:0] adr1);
        @(negedge clk);
        wb_adr = adr; wb_we = we; wb_wdat = dat; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        wb_stb = 1'b0;
        req1 = dsk_req_o;
        adr1 = dsk_adr_o;
        lat = 1;
        while (!(wb_ack_o || wb_err_o) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
        wb_cyc = 1'b0;
    endtask

    logic        ack, err;
    logic [31:0] rd;
    int          lat;
    logic [3:0]  r1;
    logic [10:0] a1;
    logic        saw;

    task automatic reg_wr(input logic [1:0] idx, input logic [31:0] val);
        wb_xfer(REGA + 32'(idx), 1'b1, val, ack, err, rd, lat, r1, a1);
    endtask

    task automatic reg_rd(input logic [1:0] idx, output logic [31:0] val);
        wb_xfer(REGA + 32'(idx), 1'b0, 32'h0, ack, err, val, lat, r1, a1);
    endtask

    initial begin
        dsk_dat = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        for (int d = 0; d < 4; d++) dly[d] = 3;
        errc = '0; never = '0;
        wb_rst_n = 1'b0; wb_adr = '0; wb_wdat = '0; wb_we = 1'b0; wb_stb = 1'b0; wb_cyc = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {27'h0, wb_ack_o, wb_err_o, wb_stall_o, wb_rty_o, dsk_we_o}, 32'h0);
        chk("rst_req", {28'h0, dsk_req_o}, 32'h0);
        chk("rst_adr", {21'h0, dsk_adr_o}, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        wb_rst_n = 1'b1;

        reg_rd(2'd0, rd);
        chk("raid_type_rst", rd, 32'h1);
        chk("reg_lat", 32'(lat), 32'd2);
        chk("reg_ack", {31'h0, ack}, 32'h1);
        reg_rd(2'd2, rd);
        chk("disk_en_rst", rd, 32'hF);

        // RAID0 write to offset 6: disk 2, disk offset 1, ack at cycle 5.
        dly[2] = 5;
        wb_xfer(BASE + 32'h6, 1'b1, 32'hDEAD_BEEF, ack, err, rd, lat, r1, a1);
        chk("r0_req", {28'h0, r1}, 32'h4);
        chk("r0_adr", {21'h0, a1}, 32'h1);
        chk("r0_wdat", dsk_dat_o, 32'hDEAD_BEEF);
        chk("r0_lat", 32'(lat), 32'd6);
        chk("r0_ack", {30'h0, ack, err}, 32'h2);

        // RAID1 write, disk 1 errors: still acked, disk 1 marked failed.
        reg_wr(2'd0, 32'h2);
        for (int d = 0; d < 4; d++) dly[d] = 3;
        errc = 4'b0010;
        wb_xfer(BASE + 32'h20, 1'b1, 32'h1234_5678, ack, err, rd, lat, r1, a1);
        chk("r1w_req", {28'h0, r1}, 32'hF);
        chk("r1w_adr", {21'h0, a1}, 32'h20);
        chk("r1w_lat", 32'(lat), 32'd4);
        chk("r1w_ack", {30'h0, ack, err}, 32'h2);
        reg_rd(2'd1, rd);
        chk("status_fail", rd, 32'h0000_0208);

        // RAID0 access to failed disk 1 is refused without a request.
        errc = '0;
        reg_wr(2'd0, 32'h1);
        wb_xfer(BASE + 32'h5, 1'b0, 32'h0, ack, err, rd, lat, r1, a1);
        chk("r0f_err", {30'h0, ack, err}, 32'h1);
        chk("r0f_req", {28'h0, r1}, 32'h0);
        chk("r0f_lat", 32'(lat), 32'd2);
        reg_rd(2'd1, rd);
        chk("status_lasterr", rd, 32'h0000_020A);
        reg_rd(2'd3, rd);
        chk("err_cnt_1", rd, 32'h1);

        reg_wr(2'd1, 32'h0000_0F04);
        reg_rd(2'd1, rd);
        chk("status_w1c", rd, 32'h0);
        reg_wr(2'd3, 32'h0);
        reg_rd(2'd3, rd);
        chk("err_cnt_clr", rd, 32'h0);

        // Mirrored write, staggered acks; last at cycle 6.
        reg_wr(2'd0, 32'h2);
        dly[0] = 2; dly[1] = 6; dly[2] = 4; dly[3] = 3;
        wb_xfer(BASE + 32'h44, 1'b1, 32'h0BAD_F00D, ack, err, rd, lat, r1, a1);
        chk("r1s_lat", 32'(lat), 32'd7);
        chk("r1s_ack", {30'h0, ack, err}, 32'h2);

        // RAID1 read with only disks 2,3 enabled reads from disk 2.
        reg_wr(2'd2, 32'hC);
        dly[2] = 4;
        wb_xfer(BASE + 32'h10, 1'b0, 32'h0, ack, err, rd, lat, r1, a1);
        chk("r1r_req", {28'h0, r1}, 32'h4);
        chk("r1r_adr", {21'h0, a1}, 32'h10);
        chk("r1r_lat", 32'(lat), 32'd5);
        chk("r1r_dat", rd, 32'hCAFE_0002);

        reg_wr(2'd2, 32'h0);
        wb_xfer(BASE + 32'h10, 1'b0, 32'h0, ack, err, rd, lat, r1, a1);
        chk("r1_empty_err", {30'h0, ack, err}, 32'h1);
        reg_wr(2'd2, 32'hF);

        wb_xfer(REGA + 32'h4, 1'b0, 32'h0, ack, err, rd, lat, r1, a1);
        chk("oor_hi_err", {30'h0, ack, err}, 32'h1);
        chk("oor_hi_lat", 32'(lat), 32'd2);
        wb_xfer(BASE - 32'h4, 1'b1, 32'h0, ack, err, rd, lat, r1, a1);
        chk("oor_lo_err", {30'h0, ack, err}, 32'h1);

        reg_wr(2'd0, 32'h3);
        wb_xfer(BASE + 32'h8, 1'b1, 32'h0, ack, err, rd, lat, r1, a1);
        chk("bad_type_err", {30'h0, ack, err}, 32'h1);
        reg_wr(2'd0, 32'h1);
        reg_rd(2'd3, rd);
        chk("err_cnt_4", rd, 32'h4);

        // Cycle abort during WAIT: disk completes, no Wishbone response.
        dly[0] = 5;
        @(negedge clk);
        wb_adr = BASE; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        wb_stb = 1'b0;
        chk("abort_req", {28'h0, dsk_req_o}, 32'h1);
        @(negedge clk);
        wb_cyc = 1'b0;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (wb_ack_o || wb_err_o) saw = 1'b1;
        end
        chk("abort_noresp", {31'h0, saw}, 32'h0);
        reg_rd(2'd0, rd);
        chk("after_abort", {30'h0, ack, err}, 32'h2);
        chk("after_abort_lat", 32'(lat), 32'd2);

        // Reset in the middle of a disk access.
        reg_wr(2'd2, 32'h7);
        never = 4'b0010;
        @(negedge clk);
        wb_adr = BASE + 32'h1; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        @(negedge clk);
        wb_stb = 1'b0;
        chk("rstmid_req_pre", {28'h0, dsk_req_o}, 32'h2);
        @(negedge clk);
        wb_rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_req", {28'h0, dsk_req_o}, 32'h0);
        chk("rstmid_stall", {31'h0, wb_stall_o}, 32'h0);
        wb_rst_n = 1'b1; wb_cyc = 1'b0; never = '0;
        reg_rd(2'd2, rd);
        chk("rstmid_disk_en", rd, 32'hF);

`ifdef SPRAID_TIMEOUT_EN
        never = 4'b1000;
        wb_xfer(BASE + 32'h3, 1'b0, 32'h0, ack, err, rd, lat, r1, a1);
        chk("tmo_err", {30'h0, ack, err}, 32'h1);
        chk("tmo_lat", 32'(lat), 32'd18);
        never = '0;
        reg_rd(2'd1, rd);
        chk("tmo_status", rd, 32'h0000_080E);
        reg_wr(2'd1, 32'h0000_0F04);
        reg_rd(2'd1, rd);
        chk("tmo_clear", rd, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timed out");
    end

endmodule
